instr_encoder: RTL
==================

# instr_encoder

Program loader for the MIPS datapath's instruction memory. It accepts one symbolic instruction per handshake (operation plus register, immediate and target fields) and encodes it into a 32-bit MIPS word. It writes the word to instruction memory at an auto-incrementing word address. It covers exactly the opcode set the control decoder recognises (lw, sw, addi, beq, bne, add, j), so test programs can be streamed in before the core leaves reset.

## Interface
- ADDR_W, 8: instruction-memory word-address width (2..16)
- BASE, 0: first word address written after reset or restart
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  restart pulse; honoured only in DONE
- cmd_valid  in  1  command present
- cmd_ready  out  1  encoder can accept; transfer when valid && ready
- cmd_op  in  3  0 lw, 1 sw, 2 addi, 3 beq, 4 bne, 5 add, 6 j, 7 reserved
- cmd_rs, cmd_rt, cmd_rd  in  5 each  register fields
- cmd_imm  in  16  offset/immediate for lw, sw, addi
- cmd_target  in  ADDR_W  absolute word address for beq, bne, j
- cmd_last  in  1  final command of program
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded word
- done  out  1  sticky; program complete
- err  out  1  sticky; reserved op, branch range, or address overflow
- wr_count  out  ADDR_W+1  words written since reset/restart

## Operation
- States: ACCEPT, WRITE, PAD (macro only), DONE. Reset → ACCEPT, pc=BASE.
- cmd_ready = (state==ACCEPT) && !reset.
- ACCEPT + handshake: register encoded word and cmd_last → WRITE.
- WRITE: imem_we=1, imem_addr=pc, imem_wdata=word. Then pc+1 and wr_count+1. Next state: last → DONE; else → ACCEPT.
- Encodings: lw 100011|rs|rt|imm; sw 101011|rs|rt|imm; addi 001000|rs|rt|imm; beq 000100|rs|rt|off; bne 000101|rs|rt|off; add 000000|rs|rt|rd|00000|100000; j 000010|zero-extended target (26 b).
- Branch off = target − (pc+1), signed, computed at ADDR_W+1 bits and sign-extended to 16. If it lies outside −32768..32767: set err, do not write, treat as reserved.
- Reserved op (7) or range error: command is consumed, err=1, no write, pc unchanged. cmd_last → DONE; otherwise stay in ACCEPT.
- Overflow: a non-last write at pc = 2^ADDR_W−1 sets err and goes to DONE. pc never wraps into a rewrite.
- DONE: done=1, cmd_ready=0. start → pc=BASE, wr_count=0, done=0, err=0, ACCEPT. start is ignored in every other state.
- reset at any cycle aborts a pending WRITE/PAD with no strobe.

## Timing
- Reset values: imem_we 0, imem_addr BASE, imem_wdata 0, done 0, err 0, wr_count 0, cmd_ready 0 during reset and 1 the following cycle.
- Handshake at cycle N → imem_we at N+1 → cmd_ready high again at N+2. Peak throughput is 1 command per 2 cycles, or 3 cycles when a pad slot is inserted.
- imem_addr and imem_wdata are registered and valid only while imem_we=1. They hold their last value otherwise.
- done and err change on the clock edge that completes the final WRITE or the consuming handshake.

## Configuration
- INSTR_ENCODER_NOP_PAD_EN defined: after each beq, bne or j, WRITE goes to PAD. PAD writes 0x00000000 at pc+1, increments pc and wr_count, then → DONE if last, else ACCEPT. The overflow rule applies to the pad write too. Branch offset stays relative to pc+1, which is the delay slot.
- Undefined: no PAD state; branches and jumps occupy a single word.

## Structure
- Shared header mips_defs: 6-bit opcode constants (OP_LW 6'h23, OP_SW 6'h2B, OP_ADDI 6'h08, OP_BEQ 6'h04, OP_BNE 6'h05, OP_RTYPE 6'h00, OP_J 6'h02), FUNCT_ADD 6'h20, 3-bit cmd_op codes. The control decoder uses the same constants.
- State encoding is local to this block.
- One sub-module, instr_fields_enc: combinational (op, fields, pc) → {word, bad}. The FSM, pc and counters stay in instr_encoder.

## Test plan
- lw rs=2 rt=3 imm=0x0004, BASE=0 → imem_we at 0, wdata 0x8C430004, wr_count 1.
- add rs=1 rt=2 rd=3 → wdata 0x00221820. Hold cmd_valid through WRITE and check cmd_ready=0 in that cycle.
- beq rs=1 rt=2 target=0 issued at pc=3 → addr 3, wdata 0x1022FFFC. With the macro, also addr 4 wdata 0x00000000 and wr_count +2.
- j target=0x10 with cmd_last → wdata 0x08000010, done=1, cmd_ready=0. Then start → wr_count=0, next write at BASE.
- op=7 → err=1, no imem_we, wr_count unchanged, next valid command still accepted. Assert reset during WRITE → no strobe, all outputs at reset values.
- ADDR_W=2, 5 non-last lw commands → writes at 0..3, then err=1, done=1, wr_count=4, and the fifth command is never accepted.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: MIPS opcode/funct constants shared with the control
// decoder, plus the 3-bit command operation codes accepted by the loader.
// No ports; imported by instr_encoder and instr_fields_enc.
package instr_encoder_pkg;

    // 6-bit primary opcodes (bits 31:26 of the instruction word)
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] FUNCT_ADD = 6'h20;

    // Command operation codes on cmd_op
    localparam logic [2:0] CMD_LW   = 3'd0;
    localparam logic [2:0] CMD_SW   = 3'd1;
    localparam logic [2:0] CMD_ADDI = 3'd2;
    localparam logic [2:0] CMD_BEQ  = 3'd3;
    localparam logic [2:0] CMD_BNE  = 3'd4;
    localparam logic [2:0] CMD_ADD  = 3'd5;
    localparam logic [2:0] CMD_J    = 3'd6;
    localparam logic [2:0] CMD_RSVD = 3'd7;

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: command handshake and instruction-memory write bus.
//   Handshake: a command transfers on a rising clk edge where cmd_valid and
//   cmd_ready are both high; the master holds all cmd_* fields stable while
//   cmd_valid is high and not yet accepted.
//   cmd_*      : symbolic instruction from the program source (master -> slave)
//   imem_*     : one-cycle write strobe, word address and data (slave -> master)
// Modports: master (program source / memory side), slave (encoder).
interface instr_encoder_if #(
    parameter int ADDR_W = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [4:0]        cmd_rs;
    logic [4:0]        cmd_rt;
    logic [4:0]        cmd_rd;
    logic [15:0]       cmd_imm;
    logic [ADDR_W-1:0] cmd_target;
    logic              cmd_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, cmd_last,
        input  cmd_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, cmd_last,
        output cmd_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_fields_enc.sv
// instr_fields_enc: combinational encoder from a symbolic command to a 32-bit
// MIPS word.
//   op, rs, rt, rd, imm, target : command fields
//   pc                          : word address the instruction will occupy
//   word                        : encoded instruction
//   bad                         : reserved op or branch offset out of range
module instr_fields_enc
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [2:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] pc,
    output logic [31:0]       word,
    output logic              bad
);
    localparam int XW = 18 - ADDR_W;

    // 18 bits holds target-(pc+1) exactly for any ADDR_W up to 16; the offset
    // fits a 16-bit field only when the top three bits are all equal.
    logic [17:0] off;
    logic        off_ok;

    always_comb begin
        off    = {{XW{1'b0}}, target} - {{XW{1'b0}}, pc} - 18'd1;
        off_ok = (off[17:15] == 3'b000) || (off[17:15] == 3'b111);
        word   = '0;
        bad    = 1'b0;
        case (op)
            CMD_LW:   word = {OP_LW,   rs, rt, imm};
            CMD_SW:   word = {OP_SW,   rs, rt, imm};
            CMD_ADDI: word = {OP_ADDI, rs, rt, imm};
            CMD_BEQ: begin
                word = {OP_BEQ, rs, rt, off[15:0]};
                bad  = !off_ok;
            end
            CMD_BNE: begin
                word = {OP_BNE, rs, rt, off[15:0]};
                bad  = !off_ok;
            end
            CMD_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD};
            CMD_J:    word = {OP_J, {(26-ADDR_W){1'b0}}, target};
            default:  bad  = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams symbolic instructions into instruction memory as
// encoded MIPS words at auto-incrementing word addresses.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : restart pulse, honoured only once the program is done
//   bus        : instr_encoder_if.slave (command handshake + imem write)
//   done, err  : sticky completion / error flags
//   wr_count   : words written since reset or restart
//   dbg_state  : current FSM state (0 ACCEPT, 1 WRITE, 2 PAD, 3 DONE)
// Optional build macro INSTR_ENCODER_NOP_PAD_EN: follow every beq/bne/j with a
// zero delay-slot word.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BASE   = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    instr_encoder_if.slave  bus,
    output logic            done,
    output logic            err,
    output logic [ADDR_W:0] wr_count,
    output logic [1:0]      dbg_state
);
    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_WRITE  = 2'd1,
        ST_PAD    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] PC_BASE = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef INSTR_ENCODER_NOP_PAD_EN
    logic              pad_q, pad_d;
`endif

    logic [31:0] enc_word;
    logic        enc_bad;
    logic        hs;

    instr_fields_enc #(.ADDR_W(ADDR_W)) u_enc (
        .op     (bus.cmd_op),
        .rs     (bus.cmd_rs),
        .rt     (bus.cmd_rt),
        .rd     (bus.cmd_rd),
        .imm    (bus.cmd_imm),
        .target (bus.cmd_target),
        .pc     (pc_q),
        .word   (enc_word),
        .bad    (enc_bad)
    );

    // Reset gates the handshake and the strobe in the same cycle, so a write
    // already loaded into the output register is dropped.
    assign bus.cmd_ready  = (state_q == ST_ACCEPT) && !reset;
    assign bus.imem_we    = we_q && !reset;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign done           = done_q;
    assign err            = err_q;
    assign wr_count       = cnt_q;
    assign dbg_state      = state_q;
    assign hs             = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef INSTR_ENCODER_NOP_PAD_EN
        pad_d   = pad_q;
`endif
        case (state_q)
            ST_ACCEPT: begin
                if (hs) begin
                    if (enc_bad) begin
                        // Command is consumed without a write.
                        err_d = 1'b1;
                        if (bus.cmd_last) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = pc_q;
                        wdata_d = enc_word;
                        last_d  = bus.cmd_last;
`ifdef INSTR_ENCODER_NOP_PAD_EN
                        pad_d   = (bus.cmd_op == CMD_BEQ) || (bus.cmd_op == CMD_BNE) ||
                                  (bus.cmd_op == CMD_J);
`endif
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q + CNT_ONE;
`ifdef INSTR_ENCODER_NOP_PAD_EN
                if ((pc_q == PC_LAST) && (!last_q || pad_q)) begin
`else
                if ((pc_q == PC_LAST) && !last_q) begin
`endif
                    // Memory full with more to write: stop rather than wrap.
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    if (pc_q != PC_LAST) pc_d = pc_q + PC_ONE;
`ifdef INSTR_ENCODER_NOP_PAD_EN
                    if (pad_q) begin
                        we_d    = 1'b1;
                        addr_d  = pc_q + PC_ONE;
                        wdata_d = '0;
                        state_d = ST_PAD;
                    end else
`endif
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end
`ifdef INSTR_ENCODER_NOP_PAD_EN
            ST_PAD: begin
                cnt_d = cnt_q + CNT_ONE;
                if ((pc_q == PC_LAST) && !last_q) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    if (pc_q != PC_LAST) pc_d = pc_q + PC_ONE;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end
`endif
            ST_DONE: begin
                if (start) begin
                    pc_d    = PC_BASE;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACCEPT;
            pc_q    <= PC_BASE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= PC_BASE;
            wdata_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef INSTR_ENCODER_NOP_PAD_EN
            pad_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef INSTR_ENCODER_NOP_PAD_EN
            pad_q   <= pad_d;
`endif
        end
    end
endmodule
